// File: rtl/phase_impair_pkg.sv
// Shared types and real-valued helpers for the phase impairment channel model.
// Phase words are unsigned fractions of a full turn; samples are signed fixed point.
package phase_impair_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_WHITE  = 2'd1,
    MODE_WIENER = 2'd2
  } mode_e;

  localparam int unsigned MODE_W    = 2;
  localparam int unsigned SAT_CNT_W = 16;
  localparam real         PI        = 3.14159265358979323846;

  // Rounded and clamped sample plus a flag telling whether the clamp engaged.
  typedef struct packed {
    logic              clip;
    logic signed [31:0] val;
  } sat_t;

  // Phase word of width w (zero-extended into 64 bits) to radians in [0, 2*pi).
  function automatic real phase_to_rad(input logic [63:0] ph, input int unsigned w);
    return real'(ph) * 2.0 * PI / $pow(2.0, real'(w));
  endfunction

  // Round half away from zero, then clamp to the signed range of a dw-bit word.
  function automatic sat_t sat_round(input real x, input int unsigned dw);
    sat_t res;
    real  r;
    real  hi;
    real  lo;
    hi       = $pow(2.0, real'(dw - 1)) - 1.0;
    lo       = -$pow(2.0, real'(dw - 1));
    r        = (x < 0.0) ? -$floor(-x + 0.5) : $floor(x + 0.5);
    res.clip = (r > hi) || (r < lo);
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    res.val = 32'(int'(r));
    return res;
  endfunction

endpackage

// File: rtl/phase_impair_if.sv
// Sample stream, configuration and status bundle between the TX baseband and the
// phase impairment model; master drives samples/config, slave is the model.
interface phase_impair_if
  import phase_impair_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PHASE_W = 32
);

  logic                     en;
  logic [MODE_W-1:0]        cfg_mode;
  logic [PHASE_W-1:0]       freq_word;
  logic [PHASE_W-1:0]       phase_init;
  logic                     phase_load;
  logic                     cnt_clr;
  logic                     valid_in;
  logic signed [DATA_W-1:0] i_in;
  logic signed [DATA_W-1:0] q_in;

  logic                     valid_out;
  logic signed [DATA_W-1:0] i_out;
  logic signed [DATA_W-1:0] q_out;
  logic [PHASE_W-1:0]       phase_out;
  logic [SAT_CNT_W-1:0]     sat_cnt;

  modport master (
    output en, cfg_mode, freq_word, phase_init, phase_load, cnt_clr,
    output valid_in, i_in, q_in,
    input  valid_out, i_out, q_out, phase_out, sat_cnt
  );

  modport slave (
    input  en, cfg_mode, freq_word, phase_init, phase_load, cnt_clr,
    input  valid_in, i_in, q_in,
    output valid_out, i_out, q_out, phase_out, sat_cnt
  );

endinterface

// File: rtl/phase_impair_mdl_gauss.sv
// Unit-variance Gaussian source: xorshift32 uniforms fed through Box-Muller.
// The value on z_c belongs to the current state; a draw consumes it and advances.
module gauss_src_mdl
  import phase_impair_pkg::*;
#(
  parameter int SEED = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic draw,
  output real  z_c
);

  localparam logic [31:0] SEED_MIX = (32'(SEED) * 32'h9E37_79B9) ^ 32'h6A09_E667;
  localparam logic [31:0] SEED_V   = (SEED_MIX == 32'h0) ? 32'h1 : SEED_MIX;
  localparam real         U_SCALE  = 4294967296.0;

  logic [31:0] st;
  logic [31:0] st_a;
  logic [31:0] st_b;
  real         u1;
  real         u2;

  function automatic logic [31:0] xs32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Two fresh uniforms per draw; u1 kept in (0,1] so the log stays finite.
  always_comb begin
    st_a = xs32(st);
    st_b = xs32(st_a);
    u1   = (real'(st_a) + 1.0) / U_SCALE;
    u2   = real'(st_b) / U_SCALE;
    z_c  = $sqrt(-2.0 * $ln(u1)) * $cos(2.0 * PI * u2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= SEED_V;
    end else if (draw) begin
      st <= st_b;
    end
  end

endmodule

// File: rtl/phase_impair_mdl.sv
// Two-stage phase impairment channel: stage 1 builds the applied phase from CFO,
// loaded phase and Gaussian noise; stage 2 rotates, rounds and saturates I/Q.
module phase_impair_mdl
  import phase_impair_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned PHASE_W   = 32,
  parameter real         NOISE_STD = 0.01,
  parameter int          SEED      = 1
) (
  input logic           clk,
  input logic           reset,
  phase_impair_if.slave bus
);

  logic                     draw;
  real                      z;
  real                      step_lsb;
  real                      step_rnd;
  logic [PHASE_W-1:0]       w_step;

  logic                     is_byp;
  logic                     is_white;
  logic [PHASE_W-1:0]       acc;
  logic [PHASE_W-1:0]       acc_base;
  logic [PHASE_W-1:0]       acc_nxt;
  logic [PHASE_W-1:0]       ph_nxt;

  logic                     s1_vld;
  logic                     s1_byp;
  logic signed [DATA_W-1:0] s1_i;
  logic signed [DATA_W-1:0] s1_q;
  logic [PHASE_W-1:0]       s1_ph;

  real                      phi;
  real                      rot_i;
  real                      rot_q;
  sat_t                     sat_i;
  sat_t                     sat_q;
  logic signed [DATA_W-1:0] res_i;
  logic signed [DATA_W-1:0] res_q;
  logic                     res_clip;

  logic                     vld_r;
  logic signed [DATA_W-1:0] i_r;
  logic signed [DATA_W-1:0] q_r;
  logic [PHASE_W-1:0]       ph_r;
  logic [SAT_CNT_W-1:0]     cnt_r;

  gauss_src_mdl #(.SEED(SEED)) u_gauss (
    .clk   (clk),
    .reset (reset),
    .draw  (draw),
    .z_c   (z)
  );

  // Noise step in phase LSBs, rounded to nearest; only consumed on accepted samples.
  always_comb begin
    draw     = bus.valid_in && bus.en;
    step_lsb = NOISE_STD * z * $pow(2.0, real'(PHASE_W)) / (2.0 * PI);
    step_rnd = (step_lsb < 0.0) ? -$floor(-step_lsb + 0.5) : $floor(step_lsb + 0.5);
    w_step   = PHASE_W'(longint'(step_rnd));
  end

  // A load replaces the accumulator before this cycle's increment is added.
  always_comb begin
    is_byp   = (bus.cfg_mode == MODE_W'(MODE_BYPASS));
    is_white = (bus.cfg_mode == MODE_W'(MODE_WHITE));
    acc_base = bus.phase_load ? bus.phase_init : acc;
    acc_nxt  = acc_base;
    ph_nxt   = '0;
    if (bus.valid_in && !is_byp) begin
      acc_nxt = acc_base + bus.freq_word + (is_white ? PHASE_W'(0) : w_step);
      ph_nxt  = is_white ? (acc_nxt + w_step) : acc_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      s1_vld <= 1'b0;
      s1_byp <= 1'b0;
      s1_i   <= '0;
      s1_q   <= '0;
      s1_ph  <= '0;
    end else if (bus.en) begin
      acc    <= acc_nxt;
      s1_vld <= bus.valid_in;
      s1_byp <= is_byp;
      s1_i   <= bus.i_in;
      s1_q   <= bus.q_in;
      s1_ph  <= ph_nxt;
    end
  end

  // Rotation by the stage-1 phase; bypass samples pass through untouched.
  always_comb begin
    phi      = phase_to_rad(64'(s1_ph), PHASE_W);
    rot_i    = real'(s1_i) * $cos(phi) - real'(s1_q) * $sin(phi);
    rot_q    = real'(s1_i) * $sin(phi) + real'(s1_q) * $cos(phi);
    sat_i    = sat_round(rot_i, DATA_W);
    sat_q    = sat_round(rot_q, DATA_W);
    res_i    = s1_byp ? s1_i : DATA_W'(sat_i.val);
    res_q    = s1_byp ? s1_q : DATA_W'(sat_q.val);
    res_clip = !s1_byp && (sat_i.clip || sat_q.clip);
  end

  // A held stage never re-presents its sample: valid drops while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_r <= 1'b0;
      i_r   <= '0;
      q_r   <= '0;
      ph_r  <= '0;
    end else if (bus.en) begin
      vld_r <= s1_vld;
      if (s1_vld) begin
        i_r  <= res_i;
        q_r  <= res_q;
        ph_r <= s1_ph;
      end
    end else begin
      vld_r <= 1'b0;
    end
  end

  // Clip counter: one per clipped sample, sticky at all-ones, clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (bus.cnt_clr) begin
      cnt_r <= '0;
    end else if (bus.en && s1_vld && res_clip && (cnt_r != '1)) begin
      cnt_r <= cnt_r + SAT_CNT_W'(1);
    end
  end

  assign bus.valid_out = vld_r;
  assign bus.i_out     = i_r;
  assign bus.q_out     = q_r;
  assign bus.phase_out = ph_r;
  assign bus.sat_cnt   = cnt_r;

endmodule

// File: tb/tb_phase_impair_mdl.sv
// Scoreboard bench for phase_impair_mdl: a deterministic instance checked sample by
// sample against a turn/rotation model, plus a noisy instance checked statistically.
module tb_phase_impair_mdl;

  localparam int unsigned DW   = 16;
  localparam int unsigned PW   = 32;
  localparam real         TPI  = 3.14159265358979323846;
  localparam real         TURN = 4294967296.0;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  phase_impair_if #(.DATA_W(DW), .PHASE_W(PW)) bus ();
  phase_impair_if #(.DATA_W(DW), .PHASE_W(PW)) nbus ();

  phase_impair_mdl #(.DATA_W(DW), .PHASE_W(PW), .NOISE_STD(0.0), .SEED(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  phase_impair_mdl #(.DATA_W(DW), .PHASE_W(PW), .NOISE_STD(0.05), .SEED(7)) ndut (
    .clk   (clk),
    .reset (reset),
    .bus   (nbus)
  );

  typedef struct {
    int          i;
    int          q;
    logic [31:0] ph;
    bit          clip;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  int          checks  = 0;
  int          errors  = 0;
  int          en_cyc  = 0;
  int          exp_sat = 0;
  logic [31:0] m_acc   = '0;
  logic [1:0]  m_mode  = 2'd0;
  logic [31:0] m_freq  = '0;
  logic        m_en    = 1'b1;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  function automatic int rnd_clamp(input real v, inout bit c);
    real r;
    r = (v < 0.0) ? -$floor(-v + 0.5) : $floor(v + 0.5);
    if (r > 32767.0) begin
      c = 1'b1;
      return 32767;
    end
    if (r < -32768.0) begin
      c = 1'b1;
      return -32768;
    end
    return int'(r);
  endfunction

  // Ideal complex rotation by ph/2^32 of a turn.
  function automatic void ref_rot(input int i, input int q, input logic [31:0] ph,
                                  output int oi, output int oq, output bit clip);
    real a;
    a    = 2.0 * TPI * real'(ph) / TURN;
    clip = 1'b0;
    oi   = rnd_clamp(real'(i) * $cos(a) - real'(q) * $sin(a), clip);
    oq   = rnd_clamp(real'(i) * $sin(a) + real'(q) * $cos(a), clip);
  endfunction

  // Drive one cycle and, for an accepted sample, push what must come out.
  task automatic step(input bit v, input int i, input int q, input bit ld,
                      input logic [31:0] init, input bit clr);
    exp_t e;
    @(negedge clk);
    bus.en         = m_en;
    bus.cfg_mode   = m_mode;
    bus.freq_word  = m_freq;
    bus.valid_in   = v;
    bus.i_in       = 16'(i);
    bus.q_in       = 16'(q);
    bus.phase_load = ld;
    bus.phase_init = init;
    bus.cnt_clr    = clr;
    if (m_en) begin
      if (ld) m_acc = init;
      if (v) begin
        if (m_mode == 2'd0) begin
          e.i    = i;
          e.q    = q;
          e.ph   = '0;
          e.clip = 1'b0;
        end else begin
          m_acc = m_acc + m_freq;
          e.ph  = m_acc;
          ref_rot(i, q, m_acc, e.i, e.q, e.clip);
        end
        e.due = en_cyc + 2;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.valid_in   = 1'b0;
    bus.phase_load = 1'b0;
    bus.cnt_clr    = 1'b0;
    reset          = 1'b1;
    #1;
    chk("rst_valid_out", bus.valid_out, 0);
    chk("rst_i_out", bus.i_out, 0);
    chk("rst_q_out", bus.q_out, 0);
    chk("rst_phase_out", bus.phase_out, 0);
    chk("rst_sat_cnt", bus.sat_cnt, 0);
    sbq.delete();
    m_acc   = '0;
    exp_sat = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Output monitor: pops the scoreboard whenever the model presents a sample.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (bus.en) en_cyc++;
        if (!bus.en) chk("valid_out_while_disabled", bus.valid_out, 0);
        if (bus.valid_out) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got i=%0d q=%0d required no sample", bus.i_out, bus.q_out);
          end else begin
            e = sbq.pop_front();
            chk("i_out", bus.i_out, e.i);
            chk("q_out", bus.q_out, e.q);
            chk("phase_out", bus.phase_out, e.ph);
            chk("latency", en_cyc, e.due);
            if (e.clip && exp_sat < 65535) exp_sat++;
          end
        end
        if (bus.cnt_clr) exp_sat = 0;
        if (bus.valid_out) chk("sat_cnt", bus.sat_cnt, exp_sat);
      end
    end
  end

  // Drive the noisy instance with a constant tone and gather phase statistics.
  task automatic noise_run(input logic [1:0] mode, input int n, output int cnt,
                           output real mean, output real sd);
    logic [31:0] prev;
    logic [31:0] d;
    bit          have_prev = 1'b0;
    real         x;
    real         s  = 0.0;
    real         s2 = 0.0;
    cnt  = 0;
    prev = '0;
    @(negedge clk);
    nbus.en         = 1'b1;
    nbus.cfg_mode   = mode;
    nbus.freq_word  = '0;
    nbus.phase_load = 1'b1;
    nbus.phase_init = '0;
    nbus.valid_in   = 1'b1;
    nbus.i_in       = 16'(10000);
    nbus.q_in       = '0;
    @(negedge clk);
    nbus.phase_load = 1'b0;
    for (int c = 0; c < n + 20 && cnt < n; c++) begin
      @(posedge clk);
      #1;
      if (nbus.valid_out) begin
        d = (mode == 2'd1) ? nbus.phase_out : (nbus.phase_out - prev);
        if (mode == 2'd1 || have_prev) begin
          x   = real'($signed(d)) * 2.0 * TPI / TURN;
          s  += x;
          s2 += x * x;
          cnt++;
        end
        prev      = nbus.phase_out;
        have_prev = 1'b1;
      end
    end
    @(negedge clk);
    nbus.valid_in = 1'b0;
    nbus.en       = 1'b0;
    mean = (cnt > 0) ? s / real'(cnt) : 0.0;
    sd   = (cnt > 0) ? $sqrt(s2 / real'(cnt) - mean * mean) : 0.0;
  endtask

  initial begin
    int  got;
    real mean;
    real sd;
    reset          = 1'b1;
    bus.en         = 1'b1;
    bus.cfg_mode   = 2'd0;
    bus.freq_word  = '0;
    bus.phase_init = '0;
    bus.phase_load = 1'b0;
    bus.cnt_clr    = 1'b0;
    bus.valid_in   = 1'b0;
    bus.i_in       = '0;
    bus.q_in       = '0;
    nbus.en         = 1'b0;
    nbus.cfg_mode   = 2'd0;
    nbus.freq_word  = '0;
    nbus.phase_init = '0;
    nbus.phase_load = 1'b0;
    nbus.cnt_clr    = 1'b0;
    nbus.valid_in   = 1'b0;
    nbus.i_in       = '0;
    nbus.q_in       = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("init_valid_out", bus.valid_out, 0);
    chk("init_i_out", bus.i_out, 0);
    chk("init_phase_out", bus.phase_out, 0);
    chk("init_sat_cnt", bus.sat_cnt, 0);

    // Bypass ramp.
    m_mode = 2'd0;
    for (int k = 1; k <= 10; k++) step(1'b1, k, -k, 1'b0, '0, 1'b0);
    idle(4);

    // Quarter-turn CFO, back to back then with two-cycle gaps.
    m_mode = 2'd2;
    m_freq = 32'h4000_0000;
    for (int k = 0; k < 8; k++) step(1'b1, 1000, 0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1000, 0, 1'b0, '0, 1'b0);
      idle(2);
    end
    step(1'b1, 1000, 0, 1'b1, 32'h8000_0000, 1'b0);
    idle(4);

    // Saturation at 45 degrees, then clear coincident with a fourth clip.
    m_freq = '0;
    step(1'b1, 32767, 32767, 1'b1, 32'h2000_0000, 1'b0);
    idle(2);
    step(1'b1, 32767, 32767, 1'b0, '0, 1'b0);
    step(1'b1, 32767, 32767, 1'b0, '0, 1'b0);
    idle(3);
    chk("sat_cnt_three", bus.sat_cnt, 3);
    step(1'b1, 32767, 32767, 1'b0, '0, 1'b0);
    step(1'b0, 0, 0, 1'b0, '0, 1'b1);
    idle(3);
    chk("sat_cnt_cleared", bus.sat_cnt, 0);

    // Reset with samples in flight; next sample must see phase 0.
    m_freq = 32'h1000_0000;
    step(1'b1, 1234, -999, 1'b0, '0, 1'b0);
    step(1'b1, 1234, -999, 1'b0, '0, 1'b0);
    step(1'b1, 1234, -999, 1'b0, '0, 1'b0);
    do_reset();
    m_freq = '0;
    step(1'b1, 1000, 500, 1'b0, '0, 1'b0);
    idle(4);

    // Randomized modes, CFO, gaps, enable drops, loads and clears.
    for (int blk = 0; blk < 20; blk++) begin
      m_mode = 2'($urandom_range(0, 3));
      m_freq = $urandom();
      for (int c = 0; c < 100; c++) begin
        m_en = ($urandom_range(0, 9) != 0);
        step($urandom_range(0, 2) != 0,
             int'($urandom_range(0, 65535)) - 32768,
             int'($urandom_range(0, 65535)) - 32768,
             $urandom_range(0, 19) == 0, $urandom(),
             $urandom_range(0, 29) == 0);
      end
    end
    m_en = 1'b1;
    for (int c = 0; c < 20 && sbq.size() != 0; c++) idle(1);
    chk("scoreboard_drained", sbq.size(), 0);

    // Noise statistics on the noisy instance.
    noise_run(2'd1, 8000, got, mean, sd);
    chk("white_count", got, 8000);
    checks++;
    if (!(sd > 0.0475 && sd < 0.0525) || (mean > 0.003) || (mean < -0.003)) begin
      errors++;
      $display("FAIL white_stats: got std %f mean %f required std 0.05+/-5%% mean ~0", sd, mean);
    end
    noise_run(2'd2, 8000, got, mean, sd);
    chk("wiener_count", got, 8000);
    checks++;
    if (!(sd > 0.0475 && sd < 0.0525) || (mean > 0.003) || (mean < -0.003)) begin
      errors++;
      $display("FAIL wiener_step_stats: got std %f mean %f required std 0.05+/-5%% mean ~0", sd, mean);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_impair_mdl.md
Name: phase_impair_mdl

Overview:
Parametrised, cycle-based channel phase impairment model for the MSK modem testbench. It sits between the TX baseband I/Q and the RX front end. It applies a deterministic carrier frequency offset, a loadable static phase, and either white (per-sample) or Wiener (random-walk) Gaussian phase noise. Unlike a purely combinational rotator, it is pipelined with a valid strobe, keeps a wrapping phase accumulator and counts saturation events.

Parameters:
DATA_W, 16, signed width of I/Q in and out
PHASE_W, 32, phase accumulator width; full scale 2^PHASE_W = 2*pi rad
NOISE_STD, 0.01, real, std dev of Gaussian phase step/sample in rad; 0.0 disables noise
SEED, 1, int, seed for the model's random stream (reproducible runs)

Ports:
clk  in  1  sample clock
reset  in  1  asynchronous, active-high reset
en  in  1  model enable; when low, outputs hold and accumulator holds
cfg_mode  in  2  0=bypass, 1=white noise, 2=Wiener noise, 3=reserved (treated as 2)
freq_word  in  PHASE_W  signed per-sample phase increment (CFO)
phase_init  in  PHASE_W  value loaded into accumulator
phase_load  in  1  single-cycle pulse: acc <= phase_init
cnt_clr  in  1  synchronous clear of sat_cnt
valid_in  in  1  input sample strobe
i_in  in  DATA_W  signed in-phase
q_in  in  DATA_W  signed quadrature
valid_out  out  1  output sample strobe
i_out  out  DATA_W  signed rotated I
q_out  out  DATA_W  signed rotated Q
phase_out  out  PHASE_W  total phase applied to the sample currently on i_out/q_out
sat_cnt  out  16  count of saturated output samples

Behaviour:
- Reset (async, active-high): all outputs 0, accumulator 0, pipeline valids 0, random stream re-seeded with SEED.
- Pipeline: fixed 2-cycle latency, valid_in@n -> valid_out@n+2 with en held high. Stage 1 computes the phase; stage 2 performs rotation and saturation. No backpressure.
- Sample gaps: the accumulator advances only on cycles with valid_in&&en. Noise is drawn only on those cycles.
- Accumulator update per accepted sample: acc <= acc + freq_word + w. w is the noise step quantised to PHASE_W LSBs (round to nearest) in mode 2, and 0 otherwise. Wrap-around is modulo 2^PHASE_W with no saturation.
- Applied phase: mode 1 uses acc + w_white, where the white term is not accumulated. Modes 2 and 3 use acc after the update. The first accepted sample after a load uses phase_init + freq_word (+w).
- Mode 0 (bypass): i_out/q_out equal the delayed inputs with the same latency. The accumulator holds. phase_out = 0. sat_cnt does not change.
- phase_load coincident with valid_in: the load wins, so acc <= phase_init + freq_word (+w), and that sample uses the loaded value.
- cfg_mode/freq_word changes take effect on the next accepted sample. In-flight samples finish with their stage-1 phase.
- Rotation: I' = I*cos(phi) - Q*sin(phi); Q' = I*sin(phi) + Q*cos(phi), where phi = phase*2*pi/2^PHASE_W. Round half away from zero.
- Saturation: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1] independently on I and Q.
- sat_cnt: +1 per output sample where I or Q clipped (once per sample, not per rail). It holds at 0xFFFF. cnt_clr has priority over a same-cycle increment.
- en low: pipeline registers, accumulator and random stream hold. The valid_out of a held stage is not re-asserted; valid_out = 0 while en is low.
- Reset mid-stream: in-flight samples are discarded, with no valid_out for them after release.
- NOISE_STD = 0.0: model is fully deterministic. Modes 1 and 2 then reduce to pure CFO plus static phase.

Decomposition:
- Package phase_impair_pkg holds:
  - mode enum (MODE_BYPASS, MODE_WHITE, MODE_WIENER)
  - real constant PI
  - function phase_to_rad(PHASE_W-bit value)
  - function sat_round(real, DATA_W) returning the clamped int plus a clip flag
- One sub-module: gauss_src_mdl. It is a Box-Muller Gaussian generator with seed, enable-gated draw and a real output (unit std). It is instanced once and scaled by NOISE_STD.

Test Plan:
- Bypass: mode 0, 10 samples i=k, q=-k, one per cycle -> identical values out 2 cycles later, phase_out = 0, sat_cnt = 0.
- CFO quarter turn: mode 2, NOISE_STD = 0, freq_word = 2^30, input (1000,0) each cycle -> out (0,1000), (-1000,0), (0,-1000), (1000,0) repeating. Accumulator wraps to 0 after the 4th sample.
- Gaps and load: freq_word = 2^30, valid_in every 3rd cycle -> same 4-sample sequence as above with no extra rotation. phase_load with phase_init = 2^31 coincident with a sample -> that output is (0,-1000).
- Saturation: phase_init = 2^29 (45 deg), input (32767,32767) -> out (0,32767) with Q clipped, sat_cnt = 1. Repeat 3 times, then cnt_clr in the same cycle as a 4th clip -> sat_cnt = 0.
- Reset mid-stream: assert reset with 2 samples in flight -> valid_out = 0 and all outputs = 0 immediately. After release, the first sample uses phase 0.
- Noise statistics: NOISE_STD = 0.05, freq_word = 0, 20000 samples of (10000,0). Mode 1: measured phase std 0.05 +/- 5%. Mode 2: variance at sample n is 0.0025*n +/- 10% over 200 seeds at n = 100.
